// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared types and default widths for the data-memory arbiter
package dm_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/burst_addr_gen.sv
// rtl/burst_addr_gen.sv - loader burst base/length latch, beat counter and wrapping address
module burst_addr_gen #(
    parameter int ADDR_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] addr,
    output logic              last_beat,
    output logic              beats_left
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        beat_d = beat_q;
        if (load) begin
            base_d = base_in;
            len_d  = (len_in > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : len_in;
            beat_d = '0;
        end else if (advance) begin
            beat_d = beat_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            beat_q <= beat_d;
        end
    end

    // Truncating add gives the wrap from the top of memory back to 0.
    assign addr       = base_q + ADDR_W'(beat_q);
    assign last_beat  = (beat_q == len_q - LEN_W'(1));
    assign beats_left = (beat_q < len_q);

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - core/loader data-memory port arbiter; DM_ARB_STATS_EN adds stall/burst counters
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_BURST    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       core_req,
    input  logic                       core_we,
    input  logic [ADDR_W-1:0]          core_addr,
    input  logic [DATA_W-1:0]          core_wdata,
    output logic                       core_gnt,
    output logic                       core_rvalid,
    output logic [DATA_W-1:0]          core_rdata,
    input  logic                       ld_req,
    input  logic                       ld_we,
    input  logic [ADDR_W-1:0]          ld_base,
    input  logic [$clog2(MAX_BURST):0] ld_len,
    input  logic                       ld_wvalid,
    input  logic [DATA_W-1:0]          ld_wdata,
    output logic                       ld_wready,
    output logic                       ld_rvalid,
    output logic [DATA_W-1:0]          ld_rdata,
    output logic                       ld_done,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_we,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
`ifdef DM_ARB_STATS_EN
    ,
    output logic [15:0]                core_stall_cnt,
    output logic [15:0]                burst_cnt
`endif
);

    localparam int LEN_W = $clog2(MAX_BURST) + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              we_q, we_d;
    logic              ld_rvalid_q, ld_rvalid_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              ld_take;
    logic              ag_load, ag_advance, ag_last, ag_remain;
    logic [ADDR_W-1:0] ag_addr;

    burst_addr_gen #(
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST),
        .LEN_W     (LEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (ag_load),
        .advance    (ag_advance),
        .base_in    (ld_base),
        .len_in     (ld_len),
        .addr       (ag_addr),
        .last_beat  (ag_last),
        .beats_left (ag_remain)
    );

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        we_d        = we_q;
        ld_rvalid_d = 1'b0;
        ag_load     = 1'b0;
        ag_advance  = 1'b0;
        core_gnt    = 1'b0;
        ld_wready   = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        ld_take     = ld_req && (!core_req || starve_q == SW'(STARVE_LIMIT));

        case (state_q)
            IDLE: begin
                // The core keeps the port even in the cycle the loader wins it.
                core_gnt = core_req;
                if (core_req) begin
                    mem_addr  = core_addr;
                    mem_we    = core_we;
                    mem_wdata = core_wdata;
                end
                if (!ld_req) begin
                    starve_d = '0;
                end else if (ld_take) begin
                    starve_d = '0;
                    we_d     = ld_we;
                    ag_load  = 1'b1;
                    state_d  = (ld_len == '0) ? DONE : BURST;
                end else begin
                    starve_d = starve_q + SW'(1);
                end
            end
            BURST: begin
                mem_addr = ag_addr;
                if (we_q) begin
                    ld_wready = ag_remain;
                    if (ld_wvalid && ag_remain) begin
                        mem_we     = 1'b1;
                        mem_wdata  = ld_wdata;
                        ag_advance = 1'b1;
                        if (ag_last) state_d = DONE;
                    end
                end else begin
                    ag_advance  = 1'b1;
                    ld_rvalid_d = 1'b1;
                    if (ag_last) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign core_rvalid_d = core_gnt && !core_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            starve_q      <= '0;
            we_q          <= 1'b0;
            ld_rvalid_q   <= 1'b0;
            core_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            we_q          <= we_d;
            ld_rvalid_q   <= ld_rvalid_d;
            core_rvalid_q <= core_rvalid_d;
        end
    end

    assign ld_done     = (state_q == DONE);
    assign core_rvalid = core_rvalid_q;
    assign ld_rvalid   = ld_rvalid_q;
    assign core_rdata  = core_rvalid_q ? mem_rdata : '0;
    assign ld_rdata    = ld_rvalid_q ? mem_rdata : '0;

`ifdef DM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] bcnt_q, bcnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        bcnt_d      = bcnt_q;
        if (core_req && !core_gnt && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        if (ld_done && bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            bcnt_q      <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            bcnt_q      <= bcnt_d;
        end
    end

    assign core_stall_cnt = stall_cnt_q;
    assign burst_cnt      = bcnt_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter against a memory/transaction model
module tb_dm_arbiter;

    localparam int MAX_BURST    = 16;
    localparam int STARVE_LIMIT = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       core_req = 1'b0, core_we = 1'b0;
    logic [7:0] core_addr = '0, core_wdata = '0;
    logic       core_gnt, core_rvalid;
    logic [7:0] core_rdata;
    logic       ld_req = 1'b0, ld_we = 1'b0, ld_wvalid = 1'b0;
    logic [7:0] ld_base = '0, ld_wdata = '0;
    logic [4:0] ld_len = '0;
    logic       ld_wready, ld_rvalid, ld_done;
    logic [7:0] ld_rdata;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] dmem [256];
    logic [7:0] ref_mem [256];
    bit         mem_ready = 1'b0;

    logic [7:0] wtbl [32];
    logic [7:0] obs_waddr [$];
    logic [7:0] obs_wdata [$];
    logic [7:0] obs_rdata [$];
    int done_cyc, done_cnt, last_beat_cyc, last_rv_cyc, bubbles;
    int gnt_before_stall, stall_cyc, mem_we_cnt;
    logic extra_done;

    dm_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .ld_req      (ld_req),
        .ld_we       (ld_we),
        .ld_base     (ld_base),
        .ld_len      (ld_len),
        .ld_wvalid   (ld_wvalid),
        .ld_wdata    (ld_wdata),
        .ld_wready   (ld_wready),
        .ld_rvalid   (ld_rvalid),
        .ld_rdata    (ld_rdata),
        .ld_done     (ld_done),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory; contents seeded on the first clock.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 8'(i * 37 + 11);
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            dmem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= dmem[mem_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one loader burst from request to ld_done and records what the DUT did.
    task automatic do_burst(input logic [7:0] base, input logic [4:0] len, input logic we,
                            input int bubble_pct, input int bubble_at, input logic hold_core);
        int  beat;
        int  cyc;
        bit  bubbled;
        bit  stalled;
        obs_waddr.delete();
        obs_wdata.delete();
        obs_rdata.delete();
        done_cyc = -1; done_cnt = 0; last_beat_cyc = -1; last_rv_cyc = -1; bubbles = 0;
        gnt_before_stall = 0; stall_cyc = 0; mem_we_cnt = 0;
        beat = 0; cyc = 0; bubbled = 0; stalled = 0;
        while (done_cnt == 0 && cyc < 200) begin
            @(negedge clk);
            ld_req = 1'b1; ld_we = we; ld_base = base; ld_len = len;
            core_req = hold_core; core_we = 1'b0; core_addr = 8'($urandom);
            ld_wdata  = wtbl[beat];
            ld_wvalid = !((beat == bubble_at && !bubbled) || (int'($urandom_range(99)) < bubble_pct));
            #1;
            if (mem_we) begin
                obs_waddr.push_back(mem_addr);
                obs_wdata.push_back(mem_wdata);
                mem_we_cnt++;
            end
            if (ld_wready && ld_wvalid) begin
                beat++;
                last_beat_cyc = cyc;
            end else if (ld_wready) begin
                bubbles++;
                if (beat == bubble_at) bubbled = 1;
            end
            if (ld_rvalid) begin
                obs_rdata.push_back(ld_rdata);
                last_rv_cyc = cyc;
            end
            if (hold_core) begin
                if (!core_gnt) begin
                    stalled = 1;
                    stall_cyc++;
                end else if (!stalled) begin
                    gnt_before_stall++;
                end
            end
            if (ld_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            cyc++;
        end
        @(negedge clk);
        ld_req = 1'b0; ld_wvalid = 1'b0; core_req = 1'b0;
        #1;
        extra_done = ld_done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (core_gnt !== 1'b0)    begin errors++; $display("FAIL reset_core_gnt: got %b expected 0", core_gnt); end
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL reset_core_rvalid: got %b expected 0", core_rvalid); end
        checks++; if (ld_wready !== 1'b0)   begin errors++; $display("FAIL reset_ld_wready: got %b expected 0", ld_wready); end
        checks++; if (ld_rvalid !== 1'b0)   begin errors++; $display("FAIL reset_ld_rvalid: got %b expected 0", ld_rvalid); end
        checks++; if (ld_done !== 1'b0)     begin errors++; $display("FAIL reset_ld_done: got %b expected 0", ld_done); end
        checks++; if (mem_we !== 1'b0)      begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00)
            begin errors++; $display("FAIL reset_mem_bus: got addr %h data %h expected 00 00", mem_addr, mem_wdata); end
        checks++; if (core_rdata !== 8'h00 || ld_rdata !== 8'h00)
            begin errors++; $display("FAIL reset_rdata: got core %h ld %h expected 00 00", core_rdata, ld_rdata); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_core_only();
        logic       op_we   [25];
        logic [7:0] op_addr [25];
        logic [7:0] op_data [25];
        logic       prev_rd;
        logic [7:0] prev_exp;
        op_we[0] = 1'b1; op_addr[0] = 8'h10; op_data[0] = 8'h5A;
        op_we[1] = 1'b0; op_addr[1] = 8'h10; op_data[1] = 8'h00;
        for (int i = 2; i < 24; i++) begin
            op_we[i]   = 1'($urandom);
            op_addr[i] = 8'($urandom_range(15)) + 8'h10;
            op_data[i] = 8'($urandom);
        end
        prev_rd = 1'b0; prev_exp = '0;
        for (int i = 0; i <= 24; i++) begin
            @(negedge clk);
            core_req = (i < 24);
            if (i < 24) begin
                core_we = op_we[i]; core_addr = op_addr[i]; core_wdata = op_data[i];
            end
            #1;
            checks++;
            if (core_rvalid !== prev_rd) begin
                errors++; $display("FAIL core_rvalid op%0d: got %b expected %b", i, core_rvalid, prev_rd);
            end else if (prev_rd && core_rdata !== prev_exp) begin
                errors++; $display("FAIL core_rdata op%0d: got %h expected %h", i, core_rdata, prev_exp);
            end
            if (i < 24) begin
                checks++;
                if (core_gnt !== 1'b1 || mem_we !== op_we[i] || mem_addr !== op_addr[i]) begin
                    errors++;
                    $display("FAIL core_grant op%0d: got gnt %b we %b addr %h expected 1 %b %h",
                             i, core_gnt, mem_we, mem_addr, op_we[i], op_addr[i]);
                end
                prev_rd  = !op_we[i];
                prev_exp = ref_mem[op_addr[i]];
                if (op_we[i]) ref_mem[op_addr[i]] = op_data[i];
            end
        end
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 32; i++) wtbl[i] = 8'(i + 1);
        do_burst(8'hFE, 5'd4, 1'b1, 0, 1, 1'b0);
        checks++; if (obs_waddr.size() != 4)
            begin errors++; $display("FAIL wburst_count: got %0d expected 4", obs_waddr.size()); end
        for (int i = 0; i < 4 && i < obs_waddr.size(); i++) begin
            logic [7:0] ea;
            ea = 8'(8'hFE + i);
            checks++;
            if (obs_waddr[i] !== ea || obs_wdata[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL wburst_beat%0d: got addr %h data %h expected %h %h", i, obs_waddr[i], obs_wdata[i], ea, 8'(i + 1));
            end
        end
        checks++; if (bubbles != 1) begin errors++; $display("FAIL wburst_bubbles: got %0d expected 1", bubbles); end
        checks++; if (done_cnt != 1 || done_cyc != last_beat_cyc + 1 || done_cyc != 6)
            begin errors++; $display("FAIL wburst_done: got cnt %0d cyc %0d expected 1 6", done_cnt, done_cyc); end
        checks++; if (extra_done !== 1'b0) begin errors++; $display("FAIL wburst_single_pulse: got %b expected 0", extra_done); end
        for (int i = 0; i < 4; i++) ref_mem[8'(8'hFE + i)] = 8'(i + 1);
    endtask

    task automatic test_read_burst();
        do_burst(8'hFE, 5'd4, 1'b0, 0, -1, 1'b0);
        checks++; if (obs_rdata.size() != 4)
            begin errors++; $display("FAIL rburst_count: got %0d expected 4", obs_rdata.size()); end
        for (int i = 0; i < 4 && i < obs_rdata.size(); i++) begin
            checks++;
            if (obs_rdata[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL rburst_data%0d: got %h expected %h", i, obs_rdata[i], 8'(i + 1));
            end
        end
        checks++; if (done_cnt != 1 || done_cyc != 5 || last_rv_cyc != done_cyc)
            begin errors++; $display("FAIL rburst_done: got cyc %0d last_rv %0d expected 5 5", done_cyc, last_rv_cyc); end
        checks++; if (mem_we_cnt != 0) begin errors++; $display("FAIL rburst_no_write: got %0d expected 0", mem_we_cnt); end
    endtask

    task automatic test_starvation();
        logic [7:0] base;
        base = 8'h80;
        for (int i = 0; i < 32; i++) wtbl[i] = 8'($urandom);
        do_burst(base, 5'd3, 1'b1, 0, -1, 1'b1);
        checks++; if (gnt_before_stall != STARVE_LIMIT + 1)
            begin errors++; $display("FAIL starve_grant_cycles: got %0d expected %0d", gnt_before_stall, STARVE_LIMIT + 1); end
        checks++; if (stall_cyc != 3 + 1)
            begin errors++; $display("FAIL starve_core_stall: got %0d expected 4", stall_cyc); end
        checks++; if (done_cyc != STARVE_LIMIT + 1 + 3)
            begin errors++; $display("FAIL starve_done_cyc: got %0d expected %0d", done_cyc, STARVE_LIMIT + 4); end
        checks++; if (obs_waddr.size() != 3)
            begin errors++; $display("FAIL starve_writes: got %0d expected 3", obs_waddr.size()); end
        for (int i = 0; i < 3 && i < obs_waddr.size(); i++) begin
            checks++;
            if (obs_waddr[i] !== 8'(base + i) || obs_wdata[i] !== wtbl[i]) begin
                errors++; $display("FAIL starve_beat%0d: got %h %h expected %h %h", i, obs_waddr[i], obs_wdata[i], 8'(base + i), wtbl[i]);
            end
            ref_mem[8'(base + i)] = wtbl[i];
        end
    endtask

    task automatic test_len_edges();
        logic [7:0] base;
        do_burst(8'h30, 5'd0, 1'b1, 0, -1, 1'b0);
        checks++; if (done_cnt != 1 || done_cyc != 1)
            begin errors++; $display("FAIL len0_done: got cnt %0d cyc %0d expected 1 1", done_cnt, done_cyc); end
        checks++; if (mem_we_cnt != 0) begin errors++; $display("FAIL len0_no_write: got %0d expected 0", mem_we_cnt); end
        base = 8'hF8;
        for (int i = 0; i < 32; i++) wtbl[i] = 8'($urandom);
        do_burst(base, 5'd20, 1'b1, 0, -1, 1'b0);
        checks++; if (obs_waddr.size() != MAX_BURST)
            begin errors++; $display("FAIL len20_clamp: got %0d expected %0d", obs_waddr.size(), MAX_BURST); end
        for (int i = 0; i < MAX_BURST && i < obs_waddr.size(); i++) begin
            checks++;
            if (obs_waddr[i] !== 8'(base + i) || obs_wdata[i] !== wtbl[i]) begin
                errors++; $display("FAIL len20_beat%0d: got %h %h expected %h %h", i, obs_waddr[i], obs_wdata[i], 8'(base + i), wtbl[i]);
            end
        end
        checks++; if (done_cyc != MAX_BURST + 1)
            begin errors++; $display("FAIL len20_done: got %0d expected %0d", done_cyc, MAX_BURST + 1); end
        for (int i = 0; i < MAX_BURST; i++) ref_mem[8'(base + i)] = wtbl[i];
    endtask

    task automatic test_random_bursts();
        for (int it = 0; it < 8; it++) begin
            logic [7:0] base;
            logic [4:0] len;
            logic       we;
            int         eff;
            base = 8'($urandom);
            len  = 5'($urandom_range(20));
            we   = 1'($urandom);
            eff  = (int'(len) > MAX_BURST) ? MAX_BURST : int'(len);
            for (int i = 0; i < 32; i++) wtbl[i] = 8'($urandom);
            do_burst(base, len, we, 25, -1, 1'b0);
            checks++; if (done_cnt != 1 || extra_done !== 1'b0)
                begin errors++; $display("FAIL rnd%0d_done_pulse: got cnt %0d extra %b expected 1 0", it, done_cnt, extra_done); end
            if (we) begin
                checks++; if (obs_waddr.size() != eff)
                    begin errors++; $display("FAIL rnd%0d_wcount: got %0d expected %0d", it, obs_waddr.size(), eff); end
                for (int i = 0; i < eff && i < obs_waddr.size(); i++) begin
                    checks++;
                    if (obs_waddr[i] !== 8'(base + i) || obs_wdata[i] !== wtbl[i]) begin
                        errors++; $display("FAIL rnd%0d_wbeat%0d: got %h %h expected %h %h", it, i, obs_waddr[i], obs_wdata[i], 8'(base + i), wtbl[i]);
                    end
                end
                checks++; if (done_cyc != ((eff == 0) ? 1 : last_beat_cyc + 1))
                    begin errors++; $display("FAIL rnd%0d_wdone: got %0d last beat %0d", it, done_cyc, last_beat_cyc); end
                for (int i = 0; i < eff; i++) ref_mem[8'(base + i)] = wtbl[i];
            end else begin
                checks++; if (obs_rdata.size() != eff || mem_we_cnt != 0)
                    begin errors++; $display("FAIL rnd%0d_rcount: got %0d writes %0d expected %0d 0", it, obs_rdata.size(), mem_we_cnt, eff); end
                for (int i = 0; i < eff && i < obs_rdata.size(); i++) begin
                    checks++;
                    if (obs_rdata[i] !== ref_mem[8'(base + i)]) begin
                        errors++; $display("FAIL rnd%0d_rbeat%0d: got %h expected %h", it, i, obs_rdata[i], ref_mem[8'(base + i)]);
                    end
                end
                checks++; if (done_cyc != eff + 1)
                    begin errors++; $display("FAIL rnd%0d_rdone: got %0d expected %0d", it, done_cyc, eff + 1); end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] base;
        logic       exp_rd;
        logic [7:0] exp_data;
        base = 8'h60;
        for (int i = 0; i < 8; i++) wtbl[i] = ~ref_mem[8'(base + i)];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ld_req = 1'b1; ld_we = 1'b1; ld_base = base; ld_len = 5'd8;
            ld_wvalid = 1'b1; ld_wdata = wtbl[(c == 0) ? 0 : c - 1];
            #1;
            checks++;
            if (mem_we !== (c != 0) || (c != 0 && mem_addr !== 8'(base + c - 1))) begin
                errors++; $display("FAIL rstmid_beat_c%0d: got we %b addr %h", c, mem_we, mem_addr);
            end
        end
        @(negedge clk);
        ld_wdata = wtbl[2];
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || ld_wready !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 ||
            ld_done !== 1'b0 || ld_rvalid !== 1'b0 || core_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got we %b wready %b addr %h wdata %h done %b expected all 0",
                     mem_we, ld_wready, mem_addr, mem_wdata, ld_done);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                reset_n = 1'b1; ld_req = 1'b0; ld_wvalid = 1'b0;
            end
            #1;
            checks++;
            if (ld_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done c%0d: got %b expected 0", c, ld_done); end
        end
        ref_mem[base] = wtbl[0];
        ref_mem[8'(base + 1)] = wtbl[1];
        exp_rd = 1'b0; exp_data = '0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            core_req = (i < 8); core_we = 1'b0; core_addr = 8'(base + i);
            #1;
            if (exp_rd) begin
                checks++;
                if (core_rvalid !== 1'b1 || core_rdata !== exp_data) begin
                    errors++; $display("FAIL rstmid_mem%0d: got %b %h expected 1 %h", i - 1, core_rvalid, core_rdata, exp_data);
                end
            end
            exp_rd   = (i < 8);
            exp_data = ref_mem[8'(base + i)];
        end
        core_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
        test_reset();
        test_core_only();
        test_write_burst();
        test_read_burst();
        test_starvation();
        test_len_edges();
        test_random_bursts();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
